countdown_timer: RTL and testbench

Game round timer: loads a two-digit BCD seconds value, divides clk into a one-second tick with an internal prescaler, and counts down to 00. It emits a one-cycle pulse per elapsed second and a one-cycle time_up pulse at expiry. It supplies the per-second pulse stream that downstream pulse counters consume, and it drives the scoreboard seven-segment digits.

---
 rtl/countdown_timer_pkg.sv | 13 +
 rtl/countdown_timer_if.sv | 24 ++
 rtl/countdown_timer_tick_prescaler.sv | 20 ++
 rtl/countdown_timer.sv | 81 ++++++++
 tb/tb_countdown_timer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: state encoding, BCD limit and digit clamp shared by the timer files
package countdown_timer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX = 4'd9;
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return d > BCD_MAX ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control inputs and display/pulse outputs of the round timer
// master drives clear_time/load/load_tens/load_ones/start/pause and observes
// tens/ones/tick/time_up/running; slave is the timer side
interface countdown_timer_if;
  logic       clear_time;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       start;
  logic       pause;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tick;
  logic       time_up;
  logic       running;
  modport master (
    output clear_time, load, load_tens, load_ones, start, pause,
    input  tens, ones, tick, time_up, running
  );
  modport slave (
    input  clear_time, load, load_tens, load_ones, start, pause,
    output tens, ones, tick, time_up, running
  );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// tick_prescaler: counts enabled clk cycles, pulses wrap on the cycle the count hits DIV-1
// ports: clk, rst (async active-low), en (count enable, count held when low),
// clr (sync zero, overrides en), wrap (high while enabled at DIV-1)
module tick_prescaler #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);
  logic [DIV_W-1:0] cnt;
  assign wrap = en && cnt == DIV_W'(DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: two-digit BCD round timer counting down once per DIV clk cycles
// ports: clk, rst (async active-low), bus (countdown_timer_if.slave) carrying
// clear_time/load/load_tens/load_ones/start/pause in and tens/ones/tick/time_up/running out
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave bus
);
  state_t     state, nxt_state;
  logic [3:0] nxt_tens, nxt_ones;
  logic       nxt_tick, nxt_up, en, clr, wrap, nonzero;
  assign nonzero = (bus.tens | bus.ones) != 4'd0;
  // en/clr depend only on registered state and inputs so wrap never feeds back into them
  assign en  = state == RUN && !bus.pause && !bus.clear_time;
  assign clr = bus.clear_time || (state == IDLE && !bus.load && bus.start && nonzero);
  tick_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (clr),
    .wrap(wrap)
  );
  always_comb begin
    nxt_state = state;
    nxt_tens  = bus.tens;
    nxt_ones  = bus.ones;
    nxt_tick  = 1'b0;
    nxt_up    = 1'b0;
    if (bus.clear_time) begin
      nxt_state = IDLE;
      nxt_tens  = 4'd0;
      nxt_ones  = 4'd0;
    end else
      case (state)
        IDLE:
          if (bus.load) begin
            nxt_tens = clamp_bcd(bus.load_tens);
            nxt_ones = clamp_bcd(bus.load_ones);
          end else if (bus.start && nonzero) nxt_state = RUN;
        RUN:
          if (bus.pause) nxt_state = PAUSE;
          else if (wrap) begin
            nxt_tick = 1'b1;
            nxt_ones = bus.ones != 4'd0 ? bus.ones - 4'd1 : BCD_MAX;
            nxt_tens = bus.ones != 4'd0 ? bus.tens : bus.tens - 4'd1;
            if (bus.tens == 4'd0 && bus.ones == 4'd1) begin
              nxt_up    = 1'b1;
              nxt_state = EXPIRED;
            end
          end
        PAUSE: nxt_state = bus.start ? RUN : PAUSE;
        default:
          if (bus.load) begin
            nxt_tens  = clamp_bcd(bus.load_tens);
            nxt_ones  = clamp_bcd(bus.load_ones);
            nxt_state = IDLE;
          end
      endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= IDLE;
      bus.tens    <= 4'd0;
      bus.ones    <= 4'd0;
      bus.tick    <= 1'b0;
      bus.time_up <= 1'b0;
      bus.running <= 1'b0;
    end else begin
      state       <= nxt_state;
      bus.tens    <= nxt_tens;
      bus.ones    <= nxt_ones;
      bus.tick    <= nxt_tick;
      bus.time_up <= nxt_up;
      bus.running <= nxt_state == RUN;
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed scoreboard bench for countdown_timer with DIV=4
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  countdown_timer_if tif();
  countdown_timer #(.DIV(4), .DIV_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(tif.slave)
  );
  logic [10:0] obs;
  assign obs = {tif.tens, tif.ones, tif.tick, tif.time_up, tif.running};
  logic [10:0] sb_q[$];
  string       tag_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  mt = 4'd0;
  logic [3:0]  mo = 4'd0;
  function automatic logic [10:0] pk(input logic [3:0] t, input logic [3:0] o,
                                     input logic tk, input logic up, input logic run);
    return {t, o, tk, up, run};
  endfunction
  task automatic compare();
    logic [10:0] e;
    string tg;
    e  = sb_q.pop_front();
    tg = tag_q.pop_front();
    n_chk++;
    assert (obs === e)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, e);
    end
  endtask
  task automatic expect_now(input string tg, input logic [10:0] e);
    sb_q.push_back(e);
    tag_q.push_back(tg);
    compare();
  endtask
  task automatic cyc(input string tg, input logic [10:0] e);
    sb_q.push_back(e);
    tag_q.push_back(tg);
    @(posedge clk);
    #1;
    compare();
  endtask
  task automatic run_second(input string tg);
    logic up;
    for (int i = 0; i < 3; i++) cyc(tg, pk(mt, mo, 1'b0, 1'b0, 1'b1));
    if (mo != 4'd0) mo = mo - 4'd1;
    else begin
      mo = 4'd9;
      mt = mt - 4'd1;
    end
    up = mt == 4'd0 && mo == 4'd0;
    cyc(tg, pk(mt, mo, 1'b1, up, !up));
  endtask
  task automatic do_load(input string tg, input logic [3:0] t, input logic [3:0] o,
                         input logic [3:0] et, input logic [3:0] eo);
    tif.load_tens = t;
    tif.load_ones = o;
    tif.load = 1'b1;
    mt = et;
    mo = eo;
    cyc(tg, pk(et, eo, 1'b0, 1'b0, 1'b0));
    tif.load = 1'b0;
  endtask
  task automatic do_clear(input string tg);
    tif.clear_time = 1'b1;
    mt = 4'd0;
    mo = 4'd0;
    cyc(tg, pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    tif.clear_time = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tif.clear_time = 1'b0;
    tif.load = 1'b0;
    tif.load_tens = 4'd0;
    tif.load_ones = 4'd0;
    tif.start = 1'b0;
    tif.pause = 1'b0;
    #3;
    expect_now("reset", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    #9 rst = 1'b1;
    @(posedge clk);
    #1;
    do_load("s1_load", 4'd1, 4'd2, 4'd1, 4'd2);
    tif.start = 1'b1;
    cyc("s1_start", pk(4'd1, 4'd2, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    repeat (3) run_second("s1_tick");
    do_clear("s1_clear");
    do_load("s2_load", 4'd0, 4'd2, 4'd0, 4'd2);
    tif.start = 1'b1;
    cyc("s2_start", pk(4'd0, 4'd2, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    repeat (2) run_second("s2_tick");
    tif.start = 1'b1;
    repeat (20) cyc("s2_expired", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    tif.start = 1'b0;
    do_load("s3_load", 4'd0, 4'd5, 4'd0, 4'd5);
    tif.start = 1'b1;
    cyc("s3_start", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    repeat (2) cyc("s3_run", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b1));
    tif.pause = 1'b1;
    repeat (4) cyc("s3_pause", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b0));
    tif.pause = 1'b0;
    repeat (6) cyc("s3_hold", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b0));
    tif.start = 1'b1;
    cyc("s3_resume", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    cyc("s3_resume_wait", pk(4'd0, 4'd5, 1'b0, 1'b0, 1'b1));
    cyc("s3_resume_tick", pk(4'd0, 4'd4, 1'b1, 1'b0, 1'b1));
    tif.pause = 1'b1;
    tif.start = 1'b1;
    cyc("s3_both", pk(4'd0, 4'd4, 1'b0, 1'b0, 1'b0));
    tif.pause = 1'b0;
    tif.start = 1'b0;
    cyc("s3_both_hold", pk(4'd0, 4'd4, 1'b0, 1'b0, 1'b0));
    do_clear("s3_clear");
    do_load("s4_clamp", 4'hF, 4'hA, 4'd9, 4'd9);
    do_load("s4_zero", 4'd0, 4'd0, 4'd0, 4'd0);
    tif.start = 1'b1;
    repeat (6) cyc("s4_zero_start", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    tif.start = 1'b0;
    do_load("s5_load", 4'd0, 4'd7, 4'd0, 4'd7);
    tif.start = 1'b1;
    cyc("s5_start", pk(4'd0, 4'd7, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    tif.load_tens = 4'd3;
    tif.load_ones = 4'd3;
    tif.load = 1'b1;
    cyc("s5_load_ignored", pk(4'd0, 4'd7, 1'b0, 1'b0, 1'b1));
    tif.load = 1'b0;
    repeat (2) cyc("s5_run", pk(4'd0, 4'd7, 1'b0, 1'b0, 1'b1));
    do_clear("s5_clear");
    repeat (6) cyc("s5_after_clear", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    do_load("s6_load", 4'd0, 4'd3, 4'd0, 4'd3);
    tif.start = 1'b1;
    cyc("s6_start", pk(4'd0, 4'd3, 1'b0, 1'b0, 1'b1));
    tif.start = 1'b0;
    cyc("s6_run", pk(4'd0, 4'd3, 1'b0, 1'b0, 1'b1));
    #2 rst = 1'b0;
    #1;
    expect_now("s6_async", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    tif.start = 1'b1;
    repeat (3) cyc("s6_start_ignored", pk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
    tif.start = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
